// File: rtl/mmio_audio_out.sv
// Memory-mapped buzzer/LED peripheral: tone and duration registers drive
// a square-wave note generator; LED register drives the board LEDs.
module mmio_audio_out #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        writeEn,
  input  logic [31:0] writeData,
  input  logic        readEn,
  output logic [31:0] readData,
  output logic [7:0]  leds,
  output logic        audioOut,
  output logic        busy
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_MS - 1);

  localparam logic [31:0] A_TONE = 32'hFFFF_0010;
  localparam logic [31:0] A_DUR  = 32'hFFFF_0014;
  localparam logic [31:0] A_LED  = 32'hFFFF_0018;
  localparam logic [31:0] A_STAT = 32'hFFFF_001C;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_nx;
  logic [19:0]   tone, tone_nx;
  logic [15:0]   ms_cnt, ms_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [19:0]   half, half_nx;
  logic          audio_nx;
  logic [31:0]   rd_mux;

  logic        wr_tone, wr_dur, wr_led;
  logic [15:0] dur_val;
  logic [19:0] tone_val;

  assign wr_tone  = writeEn && (address == A_TONE);
  assign wr_dur   = writeEn && (address == A_DUR);
  assign wr_led   = writeEn && (address == A_LED);
  assign dur_val  = writeData[15:0];
  assign tone_val = writeData[19:0];
  assign busy     = (state == PLAY);

  always_comb begin
    state_nx = state;
    tone_nx  = wr_tone ? tone_val : tone;
    ms_nx    = ms_cnt;
    tick_nx  = tick;
    half_nx  = half;
    audio_nx = audioOut;
    unique case (state)
      IDLE: begin
        if (wr_dur && dur_val != 16'd0 && tone != 20'd0) begin
          state_nx = PLAY;
          ms_nx    = dur_val;
          tick_nx  = TICK_MAX;
          half_nx  = tone - 20'd1;
          audio_nx = 1'b0;
        end
      end
      PLAY: begin
        if (wr_dur && dur_val != 16'd0) begin
          ms_nx    = dur_val;
          tick_nx  = TICK_MAX;
          half_nx  = tone - 20'd1;
          audio_nx = 1'b0;
        end else if (wr_dur || (wr_tone && tone_val == 20'd0)) begin
          state_nx = IDLE;
          ms_nx    = '0;
          tick_nx  = '0;
          half_nx  = '0;
          audio_nx = 1'b0;
        end else begin
          if (half == 20'd0) begin
            audio_nx = ~audioOut;
            half_nx  = tone - 20'd1;
          end else begin
            half_nx = half - 20'd1;
          end
          // the last millisecond ending overrides any toggle on that edge
          if (tick == '0) begin
            if (ms_cnt <= 16'd1) begin
              state_nx = IDLE;
              ms_nx    = '0;
              tick_nx  = '0;
              half_nx  = '0;
              audio_nx = 1'b0;
            end else begin
              ms_nx   = ms_cnt - 16'd1;
              tick_nx = TICK_MAX;
            end
          end else begin
            tick_nx = tick - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (address == A_TONE): rd_mux = {12'b0, tone};
      (address == A_DUR):  rd_mux = {16'b0, ms_cnt};
      (address == A_LED):  rd_mux = {24'b0, leds};
      (address == A_STAT): rd_mux = {31'b0, busy};
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tone     <= '0;
      ms_cnt   <= '0;
      tick     <= '0;
      half     <= '0;
      audioOut <= 1'b0;
      leds     <= '0;
      readData <= '0;
    end else begin
      state    <= state_nx;
      tone     <= tone_nx;
      ms_cnt   <= ms_nx;
      tick     <= tick_nx;
      half     <= half_nx;
      audioOut <= audio_nx;
      if (wr_led) leds <= writeData[7:0];
      if (readEn) readData <= rd_mux;
    end
  end

endmodule

// File: tb/tb_mmio_audio_out.sv
// Directed bench for mmio_audio_out at 10 ticks per ms.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_audio_out;

  localparam logic [31:0] A_TONE = 32'hFFFF_0010;
  localparam logic [31:0] A_DUR  = 32'hFFFF_0014;
  localparam logic [31:0] A_LED  = 32'hFFFF_0018;
  localparam logic [31:0] A_STAT = 32'hFFFF_001C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        writeEn;
  logic [31:0] writeData;
  logic        readEn;
  logic [31:0] readData;
  logic [7:0]  leds;
  logic        audioOut;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mmio_audio_out #(.TICKS_PER_MS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .writeEn   (writeEn),
    .writeData (writeData),
    .readEn    (readEn),
    .readData  (readData),
    .leds      (leds),
    .audioOut  (audioOut),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writeData = d;
    writeEn   = 1'b1;
    @(negedge clk);
    writeEn   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    address = a;
    readEn  = 1'b1;
    @(negedge clk);
    readEn  = 1'b0;
  endtask

  function automatic logic [31:0] sq(input int k, input int h, input int len);
    return (k < len) ? 32'((k / h) % 2) : 32'd0;
  endfunction

  initial begin
    reset = 1'b0; address = '0; writeEn = 1'b0;
    writeData = '0; readEn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdata", readData, 32'd0);
    check("rst_leds", {24'b0, leds}, 32'd0);
    check("rst_audio", {31'b0, audioOut}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;

    // basic note: half-period 3, 2 ms = 20 cycles
    wr(A_TONE, 32'd3);
    wr(A_DUR, 32'd2);
    for (int k = 0; k < 25; k++) begin
      check("t1_busy", {31'b0, busy}, 32'(k < 20));
      check("t1_audio", {31'b0, audioOut}, sq(k, 3, 20));
      @(negedge clk);
    end

    // LED write and readback
    wr(A_LED, 32'h1A5);
    check("led_out", {24'b0, leds}, 32'hA5);
    rd(A_LED);
    check("led_rd", readData, 32'hA5);
    repeat (2) @(negedge clk);
    check("rd_hold", readData, 32'hA5);
    rd(A_TONE);
    check("tone_rd", readData, 32'd3);
    rd(A_DUR);
    check("dur_rd_idle", readData, 32'd0);

    // zero tone: play command ignored
    wr(A_TONE, 32'd0);
    wr(A_DUR, 32'd5);
    check("t3_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_audio", {31'b0, audioOut}, 32'd0);
    rd(A_STAT);
    check("t3_status", readData, 32'd0);

    // TONE=0 write while playing stops the note
    wr(A_TONE, 32'd5);
    wr(A_DUR, 32'd1);
    rd(A_STAT);
    check("t7_status", readData, 32'd1);
    wr(A_TONE, 32'd0);
    check("t7_busy", {31'b0, busy}, 32'd0);
    check("t7_audio", {31'b0, audioOut}, 32'd0);
    rd(A_DUR);
    check("t7_dur", readData, 32'd0);

    // retrigger at cycle 12 with DUR=1
    wr(A_TONE, 32'd4);
    wr(A_DUR, 32'd3);
    for (int k = 0; k < 10; k++) begin
      check("t4_busy_a", {31'b0, busy}, 32'd1);
      check("t4_audio_a", {31'b0, audioOut}, sq(k, 4, 30));
      @(negedge clk);
    end
    wr(A_DUR, 32'd1);
    for (int k = 0; k < 12; k++) begin
      check("t4_busy_b", {31'b0, busy}, 32'(k < 10));
      check("t4_audio_b", {31'b0, audioOut}, sq(k, 4, 10));
      @(negedge clk);
    end

    // asynchronous reset mid-note
    wr(A_TONE, 32'd2);
    wr(A_DUR, 32'd4);
    repeat (6) @(negedge clk);
    check("t5_audio_pre", {31'b0, audioOut}, 32'd1);
    check("t5_busy_pre", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_audio", {31'b0, audioOut}, 32'd0);
    check("t5_leds", {24'b0, leds}, 32'd0);
    check("t5_rdata", readData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_busy_post", {31'b0, busy}, 32'd0);
    check("t5_audio_post", {31'b0, audioOut}, 32'd0);
    rd(A_TONE);
    check("t5_tone", readData, 32'd0);

    // unmapped writes leave everything alone
    wr(A_LED, 32'h5A);
    wr(A_TONE, 32'h7);
    wr(32'hFFFF_0000, 32'hFFFF_FFFF);
    wr(32'hFFFF_0020, 32'hFFFF_FFFF);
    check("t6_leds", {24'b0, leds}, 32'h5A);
    check("t6_busy", {31'b0, busy}, 32'd0);
    rd(A_TONE);
    check("t6_tone", readData, 32'd7);
    rd(A_DUR);
    check("t6_dur", readData, 32'd0);
    rd(32'hFFFF_0020);
    check("t6_other", readData, 32'd0);

    // read and write same register in one cycle
    @(negedge clk);
    address = A_LED; writeData = 32'h33;
    writeEn = 1'b1; readEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0; readEn = 1'b0;
    check("rw_old", readData, 32'h5A);
    check("rw_leds", {24'b0, leds}, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_audio_out.md
MMIO_AUDIO_OUT -- requirements
Module: mmio_audio_out

Interface
REQ-001 SHALL have parameter TICKS_PER_MS, default 50000, meaning clk cycles per millisecond (50 MHz clk).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port address  input  32  processor byte address.
REQ-005 SHALL have port writeEn  input  1  write strobe; one write per cycle it is high.
REQ-006 SHALL have port writeData  input  32  store data from processor.
REQ-007 SHALL have port readEn  input  1  read strobe.
REQ-008 SHALL have port readData  output  32  registered read data.
REQ-009 SHALL have port leds  output  8  LED register contents.
REQ-010 SHALL have port audioOut  output  1  square-wave buzzer drive.
REQ-011 SHALL have port busy  output  1  high while a note is playing.

Function
REQ-012 SHALL decode TONE at 32'hFFFF0010: half-period in clocks, bits [19:0] stored, upper bits ignored.
REQ-013 SHALL decode DUR at 32'hFFFF0014: duration in ms, bits [15:0]; a write issues a play command.
REQ-014 SHALL decode LED at 32'hFFFF0018: bits [7:0] drive leds from the cycle after the write edge.
REQ-015 SHALL decode STATUS at 32'hFFFF001C: read-only, returns {31'b0, busy}; writes ignored.
REQ-016 SHALL ignore writes to any other address; no state change.
REQ-017 SHALL, on readEn, register readData at the next edge: TONE -> {12'b0,tone}, DUR -> {16'b0,remaining ms}, LED -> {24'b0,leds}, STATUS -> {31'b0,busy}, other -> 0; readData holds its value when readEn is low.
REQ-018 SHALL, with readEn and writeEn to the same address in one cycle, return the pre-write value.
REQ-019 SHALL implement FSM IDLE/PLAY; busy = (state == PLAY).
REQ-020 SHALL, in IDLE, on a DUR write with value != 0 and tone != 0, enter PLAY at that edge, loading ms counter = value, tick counter = TICKS_PER_MS-1, half counter = tone-1, audioOut = 0.
REQ-021 SHALL, in IDLE, treat a DUR write with value 0 or while tone == 0 as a no-op (stay IDLE).
REQ-022 SHALL, in PLAY, toggle audioOut when half counter reaches 0 and reload it with the current tone-1; a new TONE write takes effect at the next reload.
REQ-023 SHALL, in PLAY, decrement the ms counter when the tick counter reaches 0 (tick reloads to TICKS_PER_MS-1); when the ms counter would reach 0, return to IDLE with audioOut = 0 at that edge.
REQ-024 SHALL, in PLAY, on a DUR write with value != 0, retrigger: reload all counters per REQ-020, audioOut = 0, stay PLAY.
REQ-025 SHALL, in PLAY, on a DUR write of 0 or a TONE write of 0, go IDLE with audioOut = 0 at that edge.
REQ-026 SHALL give a note of D ms and half-period H a PLAY duration of exactly D*TICKS_PER_MS cycles, first audioOut rise H cycles after entry.

Reset
REQ-027 SHALL, while reset is 0, hold state IDLE, tone = 0, ms/tick/half counters = 0, leds = 0, audioOut = 0, busy = 0, readData = 0.
REQ-028 SHALL, on reset assertion mid-note, stop the note immediately (asynchronously) and require a new DUR write after release.

Verification (TICKS_PER_MS = 10)
REQ-029 SHALL cover: release reset, write TONE=3, DUR=2 -> busy high 20 cycles, audioOut toggles every 3 cycles starting low, ends low, busy 0.
REQ-030 SHALL cover: write LED=32'h1A5, read LED -> leds=8'hA5, readData=32'h000000A5 one cycle after readEn.
REQ-031 SHALL cover: TONE=0 then DUR=5 -> busy stays 0, audioOut stays 0; STATUS read returns 0.
REQ-032 SHALL cover: TONE=4, DUR=3, at cycle 12 write DUR=1 -> busy high 10 further cycles, audioOut restarts low.
REQ-033 SHALL cover: TONE=2, DUR=4, pull reset low at cycle 7 -> all outputs 0 immediately, still IDLE after release.
REQ-034 SHALL cover: writes to 32'hFFFF0000 and 32'hFFFF0020 with data 32'hFFFFFFFF -> no register or output changes.
